// File: rtl/fetch_if.sv
// Handshake bundle between the fetch controller, instruction memory,
// the redirect source and the downstream consumer.
interface fetch_if;
    logic        en;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;

    modport master (
        input  en, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, fault
    );

    modport slave (
        output en, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Sequential instruction fetcher feeding a small in-order queue, with
// redirect/flush handling and a sticky fault/HALT on illegal addresses.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_WORDS = 256,
    parameter int          QDEPTH     = 2
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    localparam int              PW        = $clog2(QDEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [63:0]     MEM_BYTES = 64'(IMEM_WORDS) * 64'd4;
    localparam logic [CW-1:0]   FULL      = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t        state;
    logic [63:0]   pc;
    logic          fault_q;
    logic [31:0]   instr_q [QDEPTH];
    logic [63:0]   pc_q    [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          in_range;
    logic          redirect_ok;
    logic          pop;
    logic          push;

    // A redirect suppresses both queue operations; a pop frees a slot for a same-cycle push.
    always_comb begin
        in_range    = pc < MEM_BYTES;
        redirect_ok = (bus.redirect_pc[1:0] == 2'b00) && (bus.redirect_pc < MEM_BYTES);
        pop         = (count != '0) && bus.out_ready && !bus.redirect_valid;
        push        = (state == FETCH) && !bus.redirect_valid && in_range &&
                      ((count != FULL) || pop);
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = instr_q[head];
    assign bus.out_pc    = pc_q[head];
    assign bus.fault     = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            fault_q <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pc    <= bus.redirect_pc;
            if (redirect_ok) begin
                fault_q <= 1'b0;
                state   <= ((state == HALT) || bus.en) ? FETCH : IDLE;
            end else begin
                fault_q <= 1'b1;
                state   <= HALT;
            end
        end else begin
            if (push) begin
                instr_q[tail] <= bus.imem_instr;
                pc_q[tail]    <= pc;
                tail          <= tail + PW'(1);
                pc            <= pc + 64'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
            // Running off the end of memory halts fetch but lets queued entries drain.
            case (state)
                IDLE:    if (bus.en) state <= FETCH;
                FETCH: begin
                    if (!in_range) begin
                        fault_q <= 1'b1;
                        state   <= HALT;
                    end else if (!bus.en) begin
                        state <= IDLE;
                    end
                end
                HALT:    ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
